// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the pipeline hazard control area.
//   state_t  : hazard controller state encoding (RUN, MEM_WAIT, ABORT)
//   REG_ZERO : architectural register that is hard-wired to zero
//   load_use_hit() : decode-stage dependency on an in-flight load
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load into r0 never produces a value, so it can never cause a stall.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] load_rt,
        input logic [4:0] dec_rs,
        input logic [4:0] dec_rt
    );
        return mem_read && (load_rt != REG_ZERO) &&
               ((load_rt == dec_rs) || (load_rt == dec_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Drives PC / pipeline-register write enables and bubble controls for
// load-use stalls, taken-branch flushes and variable-latency memory waits,
// and counts stall and flush cycles.
//   clk, reset                      : clock, synchronous active-high reset
//   IF_ID_reg_rs, IF_ID_reg_rt      : decode-stage source registers
//   ID_EX_reg_rt, ID_EX_memRead     : load in execute and its destination
//   EX_branch_taken                 : branch resolved taken in execute
//   MEM_access, mem_ready           : data-memory access and completion
//   PC_write .. MEM_WB_write        : register write enables
//   IF_ID_flush .. MEM_WB_flush     : load a bubble on the next edge
//   mem_error                       : sticky memory-timeout flag
//   stall_count, flush_count        : saturating event counters
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal decode of branch / load-use / memory-wait hazards
// MEM_WAIT | pipeline frozen waiting for mem_ready, timeout counting
// ABORT    | one-cycle full flush after a memory timeout
module hazard_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_reg_rs,
    input  logic [4:0]       IF_ID_reg_rt,
    input  logic [4:0]       ID_EX_reg_rt,
    input  logic             ID_EX_memRead,
    input  logic             EX_branch_taken,
    input  logic             MEM_access,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            mem_error_d;
    logic            load_use;

    assign load_use = load_use_hit(ID_EX_memRead, ID_EX_reg_rt,
                                   IF_ID_reg_rs, IF_ID_reg_rt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            tcnt_q    <= '0;
            mem_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            mem_error <= mem_error_d;
        end
    end

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        mem_error_d  = mem_error;

        if (reset) begin
            // Fill every stage with bubbles while held in reset.
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            MEM_WB_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (MEM_access && !mem_ready) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_write = 1'b0;
                        MEM_WB_flush = 1'b1;
                        state_d      = MEM_WAIT;
                        tcnt_d       = TW'(1);
                    end else if (EX_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (load_use) begin
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // mem_ready beats the timeout when both land together.
                    if (mem_ready) begin
                        state_d = RUN;
                        tcnt_d  = '0;
                    end else begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_write = 1'b0;
                        MEM_WB_flush = 1'b1;
                        if (tcnt_q == TW'(MEM_TIMEOUT)) begin
                            state_d = ABORT;
                        end else begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                    end
                end
                ABORT: begin
                    IF_ID_flush  = 1'b1;
                    ID_EX_flush  = 1'b1;
                    MEM_WB_flush = 1'b1;
                    mem_error_d  = 1'b1;
                    state_d      = RUN;
                    tcnt_d       = '0;
                end
                default: begin
                    state_d = RUN;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~PC_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IF_ID_flush | ID_EX_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IF_ID_reg_rs, IF_ID_reg_rt, ID_EX_reg_rt;
    logic       ID_EX_memRead, EX_branch_taken, MEM_access, mem_ready;
    logic       PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic       IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_error;
    logic [3:0] stall_count, flush_count;
    logic [7:0] ctl;

    int errors = 0;
    int checks = 0;

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB write, IF_ID, ID_EX, MEM_WB flush}
    localparam logic [7:0] C_NORMAL = 8'b11111_000;
    localparam logic [7:0] C_ALL    = 8'b11111_111;
    localparam logic [7:0] C_FREEZE = 8'b00001_001;
    localparam logic [7:0] C_BRANCH = 8'b11111_110;
    localparam logic [7:0] C_LDUSE  = 8'b00111_010;

    assign ctl = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
                  IF_ID_flush, ID_EX_flush, MEM_WB_flush};

    always #5 clk = ~clk;

    hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_reg_rs(IF_ID_reg_rs), .IF_ID_reg_rt(IF_ID_reg_rt),
        .ID_EX_reg_rt(ID_EX_reg_rt), .ID_EX_memRead(ID_EX_memRead),
        .EX_branch_taken(EX_branch_taken), .MEM_access(MEM_access),
        .mem_ready(mem_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .MEM_WB_flush(MEM_WB_flush), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic idle();
        IF_ID_reg_rs = 5'd0; IF_ID_reg_rt = 5'd0; ID_EX_reg_rt = 5'd0;
        ID_EX_memRead = 1'b0; EX_branch_taken = 1'b0;
        MEM_access = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        MEM_access = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (ctl !== C_ALL) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_ALL);
        end
        checks++;
        if ({mem_error, stall_count, flush_count} !== 9'd0) begin
            errors++; $display("FAIL reset_regs: got err=%b st=%0d fl=%0d expected 0", mem_error, stall_count, flush_count);
        end
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL reset_release_normal: got %b expected %b", ctl, C_NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ID_EX_memRead = 1'b1; ID_EX_reg_rt = 5'd8; IF_ID_reg_rs = 5'd8; IF_ID_reg_rt = 5'd3;
        #1;
        checks++;
        if (ctl !== C_LDUSE) begin
            errors++; $display("FAIL load_use_rs: got %b expected %b", ctl, C_LDUSE);
        end
        tick();
        ID_EX_memRead = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL load_use_release: got %b expected %b", ctl, C_NORMAL);
        end
        checks++;
        if (stall_count !== 4'd1 || flush_count !== 4'd1) begin
            errors++; $display("FAIL load_use_counts: got st=%0d fl=%0d expected st=1 fl=1", stall_count, flush_count);
        end
        ID_EX_memRead = 1'b1; ID_EX_reg_rt = 5'd17; IF_ID_reg_rs = 5'd2; IF_ID_reg_rt = 5'd17;
        #1;
        checks++;
        if (ctl !== C_LDUSE) begin
            errors++; $display("FAIL load_use_rt: got %b expected %b", ctl, C_LDUSE);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_count !== 4'd2) begin
            errors++; $display("FAIL load_use_rt_count: got %0d expected 2", stall_count);
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        ID_EX_memRead = 1'b1; ID_EX_reg_rt = 5'd0; IF_ID_reg_rt = 5'd0; IF_ID_reg_rs = 5'd0;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL reg_zero_ctl: got %b expected %b", ctl, C_NORMAL);
        end
        tick();
        ID_EX_memRead = 1'b0; ID_EX_reg_rt = 5'd9; IF_ID_reg_rs = 5'd9;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL no_load_match_ctl: got %b expected %b", ctl, C_NORMAL);
        end
        tick();
        checks++;
        if (stall_count !== 4'd0) begin
            errors++; $display("FAIL reg_zero_count: got %0d expected 0", stall_count);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        EX_branch_taken = 1'b1;
        ID_EX_memRead = 1'b1; ID_EX_reg_rt = 5'd8; IF_ID_reg_rs = 5'd8;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++; $display("FAIL branch_over_load_use: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        idle();
        #1;
        checks++;
        if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
            errors++; $display("FAIL branch_counts: got fl=%0d st=%0d expected fl=1 st=0", flush_count, stall_count);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        MEM_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // A branch and load-use during the wait must not change the freeze.
            EX_branch_taken = (i == 1);
            ID_EX_memRead = (i == 2); ID_EX_reg_rt = 5'd4; IF_ID_reg_rs = 5'd4;
            #1;
            checks++;
            if (ctl !== C_FREEZE) begin
                errors++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, ctl, C_FREEZE);
            end
            tick();
        end
        idle();
        MEM_access = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL mem_wait_ready: got %b expected %b", ctl, C_NORMAL);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== C_NORMAL || stall_count !== 4'd3 || flush_count !== 4'd0 || mem_error !== 1'b0) begin
            errors++; $display("FAIL mem_wait_exit: got ctl=%b st=%0d fl=%0d err=%b expected %b 3 0 0",
                               ctl, stall_count, flush_count, mem_error, C_NORMAL);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        MEM_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== C_FREEZE) begin
                errors++; $display("FAIL timeout_freeze[%0d]: got %b expected %b", i, ctl, C_FREEZE);
            end
            tick();
        end
        #1;
        checks++;
        if (ctl !== C_ALL || mem_error !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got ctl=%b err=%b expected %b err=0", ctl, mem_error, C_ALL);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== C_NORMAL || mem_error !== 1'b1) begin
            errors++; $display("FAIL timeout_after_abort: got ctl=%b err=%b expected %b err=1", ctl, mem_error, C_NORMAL);
        end
        checks++;
        if (stall_count !== 4'd5 || flush_count !== 4'd1) begin
            errors++; $display("FAIL timeout_counts: got st=%0d fl=%0d expected st=5 fl=1", stall_count, flush_count);
        end
        repeat (3) tick();
        checks++;
        if (mem_error !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b expected 1", mem_error);
        end
        do_reset();
        checks++;
        if (mem_error !== 1'b0) begin
            errors++; $display("FAIL timeout_reset_clears: got %b expected 0", mem_error);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        MEM_access = 1'b1; mem_ready = 1'b0;
        repeat (4) tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORMAL) begin
            errors++; $display("FAIL race_ready_wins: got %b expected %b", ctl, C_NORMAL);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== C_NORMAL || mem_error !== 1'b0 || stall_count !== 4'd4) begin
            errors++; $display("FAIL race_exit: got ctl=%b err=%b st=%0d expected %b 0 4", ctl, mem_error, stall_count, C_NORMAL);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MEM_access = 1'b1; mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== C_ALL) begin
            errors++; $display("FAIL reset_in_wait_ctl: got %b expected %b", ctl, C_ALL);
        end
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== C_NORMAL || stall_count !== 4'd0 || flush_count !== 4'd0 || mem_error !== 1'b0) begin
            errors++; $display("FAIL reset_in_wait_after: got ctl=%b st=%0d fl=%0d err=%b expected %b 0 0 0",
                               ctl, stall_count, flush_count, mem_error, C_NORMAL);
        end
        MEM_access = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        tick();
        checks++;
        if (mem_error !== 1'b0) begin
            errors++; $display("FAIL reset_in_abort_no_error: got %b expected 0", mem_error);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ID_EX_memRead = 1'b1; ID_EX_reg_rt = 5'd8; IF_ID_reg_rs = 5'd8;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++;
                if (stall_count !== 4'd14) begin
                    errors++; $display("FAIL sat_mid: got %0d expected 14", stall_count);
                end
            end
        end
        checks++;
        if (stall_count !== 4'hF || flush_count !== 4'hF) begin
            errors++; $display("FAIL sat_full: got st=%h fl=%h expected f f", stall_count, flush_count);
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_timeout_race();
        test_reset_mid_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequences the 5-stage pipeline registers around hazards that `forwarding_unit` cannot resolve by bypassing alone: load-use dependencies, taken branches, and variable-latency data-memory accesses. It sits beside `forwarding_unit` in the ID/EX control area. It drives the PC and pipeline-register write enables and the flush (bubble) controls. It also counts stall and flush cycles for performance monitoring.

## Interface
- `MEM_TIMEOUT`, 64: maximum cycles spent in MEM_WAIT before abort (range 2–1023).
- `CNT_W`, 16: width of the saturating performance counters.

- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `IF_ID_reg_rs`, `IF_ID_reg_rt` in 5 each: source registers of the instruction in decode.
- `ID_EX_reg_rt` in 5: destination register of the load in execute.
- `ID_EX_memRead` in 1: instruction in execute is a load.
- `EX_branch_taken` in 1: branch resolved taken in execute.
- `MEM_access` in 1: instruction in the memory stage issues a data-memory read or write.
- `mem_ready` in 1: data memory completes the access this cycle.
- `PC_write`, `IF_ID_write`, `ID_EX_write`, `EX_MEM_write`, `MEM_WB_write` out 1 each: register write enables.
- `IF_ID_flush`, `ID_EX_flush`, `MEM_WB_flush` out 1 each: load a bubble (all control bits 0) on the next edge.
- `mem_error` out 1: sticky flag, set on memory timeout.
- `stall_count`, `flush_count` out `CNT_W` each: saturating event counters.

## Operation
- States: RUN, MEM_WAIT, ABORT.
- Per-cycle priority: reset > memory wait > branch flush > load-use stall > normal.
- **reset**: the next state is RUN. Counters, timeout counter and `mem_error` clear to 0.
- **RUN**, `MEM_access=1` and `mem_ready=0`:
  - Freeze: all `*_write`=0 except `MEM_WB_write`=1, with `MEM_WB_flush`=1, so the bubble drains to WB.
  - Go to MEM_WAIT and load the timeout counter with 1.
- **RUN**, `MEM_access=1` and `mem_ready=1`: treated as normal; stay in RUN.
- **MEM_WAIT**:
  - Same freeze outputs as above.
  - If `mem_ready=1`: outputs are normal this cycle and the next state is RUN.
  - Else if the timeout counter equals `MEM_TIMEOUT`: go to ABORT.
  - Else increment the timeout counter.
  - `EX_branch_taken` and load-use conditions are ignored while frozen and re-evaluated on exit.
- **ABORT** (lasts exactly one cycle):
  - `IF_ID_flush`=`ID_EX_flush`=`MEM_WB_flush`=1 and all writes=1.
  - Set `mem_error`; next state is RUN.
- **Branch** (RUN, not freezing, `EX_branch_taken=1`): `IF_ID_flush`=`ID_EX_flush`=1, all writes=1.
- **Load-use** (RUN, not freezing, no branch): triggered when `ID_EX_memRead=1`, `ID_EX_reg_rt`≠0, and `ID_EX_reg_rt` equals `IF_ID_reg_rs` or `IF_ID_reg_rt`.
  - `PC_write`=`IF_ID_write`=0 and `ID_EX_flush`=1; the other writes=1.
  - The stall clears itself because the bubble removes `ID_EX_memRead` on the next cycle.
- **Normal**: all writes=1, all flushes=0.
- **Counters**, each saturating at all-ones:
  - `stall_count` increments on every cycle with `PC_write`=0.
  - `flush_count` increments on every cycle with `IF_ID_flush` or `ID_EX_flush` asserted.

## Timing
- State, timeout counter, event counters and `mem_error` are registered.
- Control outputs are combinational from the state and the current-cycle inputs, with zero latency. This is required so stalls take effect on the same edge.
- While `reset`=1:
  - All writes=1, all flushes=1, so the pipeline fills with bubbles.
  - `mem_error`=0, both counters=0.
  - After release the block is in RUN; the first non-reset cycle uses normal decode.
- Reset asserted in MEM_WAIT or ABORT: the next state is RUN and no `mem_error` is raised.
- `mem_ready` arriving on the same cycle the timeout is reached: `mem_ready` wins and the next state is RUN.
- A load-use stall costs exactly 1 cycle; a branch flush costs 2 bubbles.

## Structure
- Shared package `pipeline_pkg`: state enumeration (RUN=2'd0, MEM_WAIT=2'd1, ABORT=2'd2) and the register-zero constant `REG_ZERO=5'd0`.
- Optional sub-module `sat_counter` (parameterised width, `inc` input), instanced twice for the event counters. All other logic is flat.

## Test plan
- Load-use stall: `ID_EX_memRead`=1, `ID_EX_reg_rt`=5'd8, `IF_ID_reg_rs`=5'd8 → that cycle `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1; next cycle normal; `stall_count`=1.
- Register-zero load: `ID_EX_reg_rt`=0 matching `IF_ID_reg_rt`=0 → no stall, `stall_count` unchanged.
- Branch during load-use: `EX_branch_taken`=1 and a load-use match in the same cycle → `IF_ID_flush`=`ID_EX_flush`=1, `PC_write`=1; `flush_count`+1, `stall_count` unchanged.
- Memory wait: `MEM_access`=1, `mem_ready` held low 3 cycles then high → 3 frozen cycles with `stall_count`=3, then RUN; `mem_error`=0.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` held low → ABORT on the 5th cycle with all flushes=1, then `mem_error`=1 and held until `reset`.
- Reset mid-wait, then saturation: `reset` pulsed in MEM_WAIT → RUN with counters 0. With `CNT_W`=4, 20 stall cycles → `stall_count`=4'hF.
